// File: rtl/fetch_receive_queue_pkg.sv
// Definitions shared across the fetch/decode stages: the NOP encoding and a log2 helper.
package fetch_receive_queue_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Ceiling log2; log2(1) = 0.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head is visible whenever not empty.
module fetch_queue_fifo
    import fetch_receive_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = log2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_receive_queue.sv
// Fetch receive side: buffers memory responses and hands single instructions to decode.
module fetch_receive_queue
    import fetch_receive_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_BITS    = 32,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned SCAN_CYCLES_MIN = 0,
    parameter int unsigned SCAN_CYCLES_MAX = 1000,
    localparam int unsigned OCC_W = log2(QUEUE_DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    input  logic [ADDRESS_BITS-1:0] i_mem_PC,
    output logic                    i_mem_ready,
    input  logic                    decode_ready,
    output logic                    inst_valid,
    output logic [31:0]             instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic [OCC_W-1:0]        occupancy,
    input  logic                    scan
);

    localparam int unsigned NUM_BYTES      = DATA_WIDTH / 8;
    localparam int unsigned LOG2_NUM_BYTES = log2(NUM_BYTES);
    localparam int unsigned ENTRY_W        = ADDRESS_BITS + DATA_WIDTH;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      head;
    logic [ADDRESS_BITS-1:0] head_pc;
    logic [DATA_WIDTH-1:0]   head_line;
    logic [31:0]             raw_instruction;

    assign i_mem_ready = ~reset & ~full;
    assign inst_valid  = ~empty & ~flush & ~reset;
    assign push        = i_mem_valid & i_mem_ready & ~flush;
    assign pop         = inst_valid & decode_ready;

    fetch_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .data  ({i_mem_PC, i_mem_data}),
        .full  (full),
        .empty (empty),
        .count (occupancy),
        .head  (head)
    );

    assign head_pc   = head[ENTRY_W-1 -: ADDRESS_BITS];
    assign head_line = head[DATA_WIDTH-1:0];

    // Word select comes from the PC bits above the byte offset; PC[1:0] is ignored.
    if (DATA_WIDTH == 32) begin : g_no_mux
        assign raw_instruction = head_line;
    end else begin : g_mux
        logic [LOG2_NUM_BYTES-3:0] word_sel;
        assign word_sel        = head_pc[LOG2_NUM_BYTES-1:2];
        assign raw_instruction = head_line[{word_sel, 5'd0} +: 32];
    end

    assign instruction = inst_valid ? raw_instruction : NOP;
    assign inst_PC     = inst_valid ? head_pc : '0;

`ifndef SYNTHESIS
    logic [31:0] cycle_count;
    logic        in_window;

    assign in_window = ($signed({1'b0, cycle_count}) >= $signed(33'(SCAN_CYCLES_MIN)))
                    && ($signed({1'b0, cycle_count}) <= $signed(33'(SCAN_CYCLES_MAX)));

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
        if (scan && in_window) begin
            $display("[fetch_receive_queue] cycle %0d occupancy %0d head_pc %h instruction %h",
                     cycle_count, occupancy, inst_PC, instruction);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_receive_queue.sv
// Directed bench for fetch_receive_queue: a 64-bit-line instance for most cases, a 32-bit one for the no-mux path.
module tb_fetch_receive_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        decode_ready;
    logic        scan;

    logic        v64;
    logic [63:0] d64;
    logic [31:0] pc64;
    logic        rdy64;
    logic        iv64;
    logic [31:0] ins64;
    logic [31:0] ipc64;
    logic [2:0]  occ64;

    logic        v32;
    logic [31:0] d32;
    logic [31:0] pc32;
    logic        rdy32;
    logic        iv32;
    logic [31:0] ins32;
    logic [31:0] ipc32;
    logic [2:0]  occ32;

    int tests;
    int failed;

    fetch_receive_queue #(.DATA_WIDTH(64), .ADDRESS_BITS(32), .QUEUE_DEPTH(4)) dut64 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .i_mem_valid  (v64),
        .i_mem_data   (d64),
        .i_mem_PC     (pc64),
        .i_mem_ready  (rdy64),
        .decode_ready (decode_ready),
        .inst_valid   (iv64),
        .instruction  (ins64),
        .inst_PC      (ipc64),
        .occupancy    (occ64),
        .scan         (scan)
    );

    fetch_receive_queue #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .QUEUE_DEPTH(4)) dut32 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .i_mem_valid  (v32),
        .i_mem_data   (d32),
        .i_mem_PC     (pc32),
        .i_mem_ready  (rdy32),
        .decode_ready (decode_ready),
        .inst_valid   (iv32),
        .instruction  (ins32),
        .inst_PC      (ipc32),
        .occupancy    (occ32),
        .scan         (scan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [63:0] data;
        logic        dr;
        logic        fl;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [2:0]  eo;
        logic        er;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check64(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [2:0] eo, input logic er);
        check({tag, " inst_valid"}, 64'(iv64), 64'(ev));
        check({tag, " instruction"}, 64'(ins64), 64'(ei));
        check({tag, " inst_PC"}, 64'(ipc64), 64'(ep));
        check({tag, " occupancy"}, 64'(occ64), 64'(eo));
        check({tag, " i_mem_ready"}, 64'(rdy64), 64'(er));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] line_of(input int k);
        return {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
    endfunction

    function automatic logic [31:0] instr_of(input int k);
        return k[0] ? (32'hB000_0000 | 32'(k)) : (32'hA000_0000 | 32'(k));
    endfunction

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        flush = 1'b0;
        decode_ready = 1'b0;
        scan = 1'b0;
        v64 = 1'b0; d64 = '0; pc64 = '0;
        v32 = 1'b0; d32 = '0; pc32 = '0;

        // Test plan 2 and 3 vectors: {v, pc, data, dr, fl, exp valid, instr, pc, occ, ready}
        vecs[0]  = '{1'b1, 32'h104, 64'hAAAA0000_BBBB1111, 1'b1, 1'b0, 1'b0, NOP,          32'h0,   3'd0, 1'b1};
        vecs[1]  = '{1'b1, 32'h108, 64'hAAAA0000_BBBB1111, 1'b1, 1'b0, 1'b1, 32'hAAAA0000, 32'h104, 3'd1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,   64'h0,                 1'b1, 1'b0, 1'b1, 32'hBBBB1111, 32'h108, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,   64'h0,                 1'b0, 1'b0, 1'b0, NOP,          32'h0,   3'd0, 1'b1};
        vecs[4]  = '{1'b1, 32'h200, 64'hB0000000_A0000000, 1'b0, 1'b0, 1'b0, NOP,          32'h0,   3'd0, 1'b1};
        vecs[5]  = '{1'b1, 32'h204, 64'hB0000001_A0000001, 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h200, 3'd1, 1'b1};
        vecs[6]  = '{1'b1, 32'h208, 64'hB0000002_A0000002, 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h200, 3'd2, 1'b1};
        vecs[7]  = '{1'b1, 32'h20C, 64'hB0000003_A0000003, 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h200, 3'd3, 1'b1};
        vecs[8]  = '{1'b1, 32'h210, 64'hB0000004_A0000004, 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h200, 3'd4, 1'b0};
        vecs[9]  = '{1'b1, 32'h210, 64'hB0000004_A0000004, 1'b1, 1'b0, 1'b1, 32'hA0000000, 32'h200, 3'd4, 1'b0};
        vecs[10] = '{1'b1, 32'h210, 64'hB0000004_A0000004, 1'b1, 1'b0, 1'b1, 32'hB0000001, 32'h204, 3'd3, 1'b1};
        vecs[11] = '{1'b0, 32'h0,   64'h0,                 1'b1, 1'b0, 1'b1, 32'hA0000002, 32'h208, 3'd3, 1'b1};
        vecs[12] = '{1'b0, 32'h0,   64'h0,                 1'b1, 1'b0, 1'b1, 32'hB0000003, 32'h20C, 3'd2, 1'b1};
        vecs[13] = '{1'b0, 32'h0,   64'h0,                 1'b1, 1'b0, 1'b1, 32'hA0000004, 32'h210, 3'd1, 1'b1};
        vecs[14] = '{1'b0, 32'h0,   64'h0,                 1'b0, 1'b0, 1'b0, NOP,          32'h0,   3'd0, 1'b1};

        // Reset state.
        tick();
        check("reset ready64", 64'(rdy64), 64'd0);
        check("reset ready32", 64'(rdy32), 64'd0);
        tick();
        check64("in reset", 1'b0, NOP, 32'h0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        check64("after reset", 1'b0, NOP, 32'h0, 3'd0, 1'b1);
        check("after reset ready32", 64'(rdy32), 64'd1);

        // 32-bit line: single push, consumed immediately.
        v32 = 1'b1; pc32 = 32'h100; d32 = 32'h0050_0093; decode_ready = 1'b1;
        #1;
        check("w32 no bypass", 64'(iv32), 64'd0);
        tick();
        v32 = 1'b0;
        #1;
        check("w32 valid", 64'(iv32), 64'd1);
        check("w32 instruction", 64'(ins32), 64'h0050_0093);
        check("w32 pc", 64'(ipc32), 64'h100);
        check("w32 occupancy", 64'(occ32), 64'd1);
        tick();
        check("w32 drained valid", 64'(iv32), 64'd0);
        check("w32 drained nop", 64'(ins32), 64'(NOP));
        check("w32 drained pc", 64'(ipc32), 64'h0);

        // Word extraction, fill to full, drain in order.
        for (int i = 0; i < 15; i++) begin
            v64 = vecs[i].v; pc64 = vecs[i].pc; d64 = vecs[i].data;
            decode_ready = vecs[i].dr; flush = vecs[i].fl;
            #1;
            check64($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].eo, vecs[i].er);
            tick();
        end

        // Hold occupancy at 2 with simultaneous push/pop; pointers wrap.
        decode_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v64 = 1'b1; pc64 = 32'h300 + 32'(4 * k); d64 = line_of(k);
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            v64 = 1'b1; pc64 = 32'h300 + 32'(4 * (j + 2)); d64 = line_of(j + 2);
            decode_ready = 1'b1;
            #1;
            check64($sformatf("steady%0d", j), 1'b1, instr_of(j), 32'h300 + 32'(4 * j), 3'd2, 1'b1);
            tick();
        end

        // Flush at occupancy 3 with an incoming line.
        decode_ready = 1'b0;
        v64 = 1'b1; pc64 = 32'h300 + 32'(4 * 12); d64 = line_of(12);
        tick();
        v64 = 1'b1; pc64 = 32'h300 + 32'(4 * 13); d64 = line_of(13);
        decode_ready = 1'b1; flush = 1'b1;
        #1;
        check64("flush cycle", 1'b0, NOP, 32'h0, 3'd3, 1'b1);
        tick();
        v64 = 1'b0; flush = 1'b0;
        #1;
        check64("post flush", 1'b0, NOP, 32'h0, 3'd0, 1'b1);
        tick();
        check64("post flush 2", 1'b0, NOP, 32'h0, 3'd0, 1'b1);

        // Reset mid-stream at occupancy 2.
        decode_ready = 1'b0;
        for (int k = 20; k < 22; k++) begin
            v64 = 1'b1; pc64 = 32'h300 + 32'(4 * k); d64 = line_of(k);
            tick();
        end
        v64 = 1'b0;
        #1;
        check64("pre reset", 1'b1, instr_of(20), 32'h350, 3'd2, 1'b1);
        reset = 1'b1;
        #1;
        check("mid reset ready", 64'(rdy64), 64'd0);
        check("mid reset valid", 64'(iv64), 64'd0);
        check("mid reset nop", 64'(ins64), 64'(NOP));
        tick();
        check64("held reset", 1'b0, NOP, 32'h0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        check64("after mid reset", 1'b0, NOP, 32'h0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
